// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg -- constants and types shared by the MEM/WB writeback stage.
//   WB_SEL_*  : writeback source select encodings (mem_wb_sel)
//   F3_L*     : load size/sign codes (mem_funct3)
//   wb_stage_t: the stage register contents
package mem_wb_stage_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_RSV  = 2'b11;  // reserved, behaves as ALU

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic [31:0] pc_plus4;
    } wb_stage_t;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// load_extend -- combinational load alignment and sign/zero extension.
//   funct3 : load size/sign code
//   offset : byte offset within the word (address bits [1:0])
//   word   : raw 32-bit word returned by memory
//   value  : extracted, extended 32-bit result
// Codes other than byte/half loads pass the full word through.
module load_extend
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        // Halfwords are aligned, so only offset[1] picks the half.
        half_sel = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  value = {24'h0, byte_sel};
            F3_LHU:  value = {16'h0, half_sel};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- MEM/WB pipeline register and writeback mux.
//   clk, rst_n        : clock, async active-low reset
//   stall, flush      : hold / kill stage (flush wins)
//   mem_*             : instruction fields from the MEM stage
//   write_port_addr   : register-file write address (registered rd)
//   write_data        : selected writeback value
//   write_en          : valid & reg_write & rd != 0
//   wb_valid          : stage holds a valid instruction
//   retire_count      : instructions leaving the stage (wraps)
// Optional feature macro WB_BYPASS_EN adds rs1/rs2_addr inputs and
// fwd_data1/2, fwd_hit1/2 outputs forwarding the current write to decode.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd_addr,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [31:0]      mem_alu_result,
    input  logic [31:0]      mem_load_data,
    input  logic [31:0]      mem_pc_plus4,
    output logic [4:0]       write_port_addr,
    output logic [31:0]      write_data,
    output logic             write_en,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retire_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [31:0]      fwd_data1,
    output logic [31:0]      fwd_data2,
    output logic             fwd_hit1,
    output logic             fwd_hit2
`endif
);

    wb_stage_t stage;
    wb_stage_t incoming;
    logic [31:0] load_val;

    assign incoming = '{valid:      mem_valid,
                        reg_write:  mem_reg_write,
                        rd:         mem_rd_addr,
                        wb_sel:     mem_wb_sel,
                        funct3:     mem_funct3,
                        alu_result: mem_alu_result,
                        load_data:  mem_load_data,
                        pc_plus4:   mem_pc_plus4};

    // An instruction retires on the edge where it leaves the stage; a
    // flushed or stalled instruction does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage        <= '0;
            retire_count <= '0;
        end else begin
            if (stage.valid && !stall && !flush)
                retire_count <= retire_count + CNT_W'(1);
            if (flush)
                stage.valid <= 1'b0;
            else if (!stall)
                stage <= incoming;
        end
    end

    load_extend u_load_extend (
        .funct3 (stage.funct3),
        .offset (stage.alu_result[1:0]),
        .word   (stage.load_data),
        .value  (load_val)
    );

    always_comb begin
        case (stage.wb_sel)
            WB_SEL_LOAD: write_data = load_val;
            WB_SEL_PC4:  write_data = stage.pc_plus4;
            default:     write_data = stage.alu_result;
        endcase
    end

    assign wb_valid        = stage.valid;
    assign write_port_addr = stage.rd;
    // Stays high through a stall: re-writing the same value is harmless.
    assign write_en        = stage.valid & stage.reg_write & (stage.rd != 5'd0);

`ifdef WB_BYPASS_EN
    assign fwd_hit1  = write_en & (rs1_addr == write_port_addr);
    assign fwd_hit2  = write_en & (rs2_addr == write_port_addr);
    assign fwd_data1 = fwd_hit1 ? write_data : 32'h0;
    assign fwd_data2 = fwd_hit2 ? write_data : 32'h0;
`endif

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of retire counter (legal 8..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: stall  input  1  hold stage contents.
REQ-005 SHALL have port: flush  input  1  kill stage contents.
REQ-006 SHALL have port: mem_valid  input  1  incoming instruction valid.
REQ-007 SHALL have port: mem_reg_write  input  1  instruction writes rd.
REQ-008 SHALL have port: mem_rd_addr  input  5  destination register.
REQ-009 SHALL have port: mem_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-010 SHALL have port: mem_funct3  input  3  load size/sign code.
REQ-011 SHALL have ports: mem_alu_result, mem_load_data, mem_pc_plus4  input  32 each  writeback candidates; alu_result[1:0] is the load byte offset.
REQ-012 SHALL have port: write_port_addr  output  5  register-file write address.
REQ-013 SHALL have port: write_data  output  32  register-file write data.
REQ-014 SHALL have port: write_en  output  1  register-file write enable.
REQ-015 SHALL have port: wb_valid  output  1  stage holds a valid instruction.
REQ-016 SHALL have port: retire_count  output  CNT_W  retired-instruction count.
REQ-017 SHALL have ports (WB_BYPASS_EN only): rs1_addr, rs2_addr  input  5; fwd_data1, fwd_data2  output  32; fwd_hit1, fwd_hit2  output  1.

Function
REQ-018 SHALL capture all mem_* inputs into stage registers on a rising clk edge; one-cycle latency from mem_* to write_* outputs.
REQ-019 SHALL give priority flush > stall > capture; flush clears the valid bit, stall holds every stage register unchanged.
REQ-020 SHALL drive write_en = wb_valid AND reg_write AND (rd != 0), combinationally from stage registers.
REQ-021 SHALL drive write_port_addr from the registered rd at all times, independent of write_en.
REQ-022 SHALL select write_data: 00 ALU result, 01 extracted load, 10 PC+4, 11 ALU result.
REQ-023 SHALL extract loads by funct3: 000 LB sign-extend byte at offset[1:0]; 001 LH sign-extend half at offset[1]; 100 LBU and 101 LHU zero-extend the same; 010 and all other codes pass the full word.
REQ-024 SHALL keep write_en asserted while stalled with valid; the repeated identical write is intended.
REQ-025 SHALL increment retire_count by 1 on each edge where wb_valid=1, stall=0 and flush=0; it wraps from all-ones to 0.
REQ-026 SHALL not count a flushed instruction.

Reset
REQ-027 SHALL, while rst_n=0, clear immediately: valid, reg_write, rd, wb_sel, funct3, data registers and retire_count; therefore write_en=0, wb_valid=0, write_data=0, write_port_addr=0.
REQ-028 SHALL load the first instruction on the first rising edge after rst_n deasserts; a reset mid-stall discards the held instruction.

Configuration
REQ-029 SHALL, with WB_BYPASS_EN defined, set fwd_hitN = write_en AND (rsN_addr == write_port_addr), and fwd_dataN = write_data on a hit, else 0, so decode sees same-cycle writes.
REQ-030 SHALL, without WB_BYPASS_EN, omit rs1/rs2/fwd_* ports and logic entirely.

Structure
REQ-031 SHALL place the wb_sel encodings and funct3 load codes as named constants in the shared pipeline package.
REQ-032 SHALL implement load extraction as a combinational sub-module load_extend (inputs funct3, offset, word; output 32-bit value).

Verification
REQ-033 SHALL verify: reset with all inputs active -> all outputs 0, retire_count 0 until after the first post-reset edge.
REQ-034 SHALL verify: LB, offset 3, load_data 0x80FF_1234 -> write_data 0xFFFF_FF80; LHU, offset 2 -> 0x0000_80FF.
REQ-035 SHALL verify: valid write to rd=0 with wb_sel=10 -> write_en=0; retire_count still increments by 1.
REQ-036 SHALL verify: stall for 3 cycles on ALU write rd=5 data 0xDEAD_BEEF -> write_en held high all 3 cycles; retire_count +1 only on release.
REQ-037 SHALL verify: flush and stall asserted together -> wb_valid=0 next cycle; retire_count unchanged.
REQ-038 SHALL verify (WB_BYPASS_EN): write rd=7 data 0x1234_5678, rs1_addr=7, rs2_addr=8 -> fwd_hit1=1, fwd_data1=0x1234_5678, fwd_hit2=0, fwd_data2=0.
